gpr_writeback: RTL

GPR_WRITEBACK -- requirements
Module: gpr_writeback

---
 rtl/gpr_writeback_pkg.sv | 15 +
 rtl/gpr_wb_arbiter.sv | 43 ++++
 rtl/gpr_writeback.sv | 81 ++++++++
 3 files changed

// File: rtl/gpr_writeback_pkg.sv
// Shared CPU package: GPR geometry and the writeback request bundle.
// Imported by the writeback arbiter and the writeback top.
package gpr_writeback_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/gpr_wb_arbiter.sv
// Two-source writeback arbiter: loads win by default, but a stalled
// ALU offer gains priority after STARVE_MAX refused cycles.
module gpr_wb_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_ready,
  output logic mem_ready
);

  localparam int CW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q;
  logic [CW-1:0] starve_cnt_d;
  logic          alu_pri;

  always_comb begin
    alu_pri   = alu_valid && (starve_cnt_q == CNT_MAX);
    mem_ready = rst_n && mem_valid && !alu_pri;
    alu_ready = rst_n && alu_valid && !mem_ready;

    starve_cnt_d = starve_cnt_q;
    if (!alu_valid || alu_ready) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/gpr_writeback.sv
// GPR writeback stage: arbitrates ALU/load results into one registered
// write port and bypasses the pending write to the read ports.
module gpr_writeback
  import gpr_writeback_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              write_enable,
  output logic [REG_W-1:0]  addrC,
  output logic [DATA_W-1:0] data_in_C,
  input  logic [REG_W-1:0]  addrA,
  input  logic [REG_W-1:0]  addrB,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data
);

  logic    we_q;
  logic    we_d;
  wb_req_t wb_q;
  wb_req_t wb_d;

  gpr_wb_arbiter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready)
  );

  // Address and data hold when idle; only the enable drops.
  always_comb begin
    we_d = 1'b0;
    wb_d = wb_q;
    unique case (1'b1)
      mem_ready: begin
        wb_d = '{rd: mem_rd, data: mem_data};
        we_d = (mem_rd != ZERO_REG);
      end
      alu_ready: begin
        wb_d = '{rd: alu_rd, data: alu_data};
        we_d = (alu_rd != ZERO_REG);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= 1'b0;
      wb_q <= '0;
    end else begin
      we_q <= we_d;
      wb_q <= wb_d;
    end
  end

  assign write_enable = we_q;
  assign addrC        = wb_q.rd;
  assign data_in_C    = wb_q.data;

  assign fwd_a_hit  = we_q && (wb_q.rd == addrA) && (addrA != ZERO_REG);
  assign fwd_b_hit  = we_q && (wb_q.rd == addrB) && (addrB != ZERO_REG);
  assign fwd_a_data = wb_q.data;
  assign fwd_b_data = wb_q.data;

endmodule
